// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame-format constants used by
// both the transmit and receive paths.
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } uart_state_e;

  localparam int unsigned BaudDivDefault       = 10416;  // 100 MHz / 9600
  localparam int unsigned FrameDataBits        = 8;
  localparam int unsigned FrameStopBitsDefault = 1;

  // Clock cycles from the falling edge of the start bit to the end of the stop bit(s).
  function automatic int unsigned frame_cycles(int unsigned baud_div, int unsigned stop_bits);
    return (1 + FrameDataBits + stop_bits) * baud_div;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running cycle counter with synchronous clear and a terminal-count flag at Limit-1.
module uart_baud_tick #(
  parameter int unsigned Limit = 4,
  parameter int unsigned Width = (Limit > 1) ? $clog2(Limit) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  output logic [Width-1:0] count,
  output logic             wrap
);

  logic [Width-1:0] count_q;

  // The owner clears at or before Limit-1, so the increment never overflows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;
  assign wrap  = (count_q == Width'(Limit - 1));

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: one-byte holding register feeding an 8N1/8N2 shift FSM, LSB first,
// with back-to-back frames when the holding register is refilled during a frame.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV  = BaudDivDefault,
  parameter int unsigned STOP_BITS = FrameStopBitsDefault,
  parameter int unsigned DATA_BITS = FrameDataBits
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned StopLen = BAUD_DIV * STOP_BITS;
  localparam int unsigned CntW    = (StopLen > 1) ? $clog2(StopLen) : 1;
  localparam int unsigned IdxW    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  uart_state_e          state_q, state_d;
  logic [7:0]           hold_data_q, hold_data_d;
  logic                 hold_full_q, hold_full_d;
  logic [7:0]           shift_q, shift_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic                 tx_q, tx_d;
  logic                 tx_ready_q, tx_busy_q, tx_done_q;
  logic                 tx_done_d;
  logic [CntW-1:0]      cnt;
  logic                 stop_end;
  logic                 bit_end;
  logic                 cnt_clear;
  logic                 accept;

  assign accept    = tx_valid & tx_ready_q;
  // One counter serves both bit lengths: STOP spans all stop bits in a single pass.
  assign bit_end   = (state_q == StStop) ? stop_end : (cnt == CntW'(BAUD_DIV - 1));
  assign cnt_clear = (state_q == StIdle) | bit_end;

  uart_baud_tick #(
    .Limit (StopLen),
    .Width (CntW)
  ) u_baud_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cnt_clear),
    .count (cnt),
    .wrap  (stop_end)
  );

  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    tx_d        = tx_q;

    // Accept needs hold empty, drain needs hold full, so the two never collide.
    if (accept) begin
      hold_data_d = tx_data;
      hold_full_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (hold_full_q) begin
          shift_d     = hold_data_q;
          hold_full_d = 1'b0;
          idx_d       = '0;
          state_d     = StStart;
          tx_d        = 1'b0;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          idx_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      StData: begin
        if (bit_end) begin
          if (idx_q == IdxW'(DATA_BITS - 1)) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
            tx_d  = shift_q[idx_d];
          end
        end
      end
      StStop: begin
        if (bit_end) begin
          if (hold_full_q) begin
            shift_d     = hold_data_q;
            hold_full_d = 1'b0;
            idx_d       = '0;
            state_d     = StStart;
            tx_d        = 1'b0;
          end else begin
            state_d = StIdle;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase

    // Registered pulse: raised one cycle early so it lands in the final stop-bit cycle.
    tx_done_d = (state_q == StStop) && (cnt == CntW'(StopLen - 2));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      hold_data_q <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      idx_q       <= '0;
      tx_q        <= 1'b1;
      tx_ready_q  <= 1'b1;
      tx_busy_q   <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      tx_q        <= tx_d;
      tx_ready_q  <= ~hold_full_d;
      tx_busy_q   <= (state_d != StIdle) | hold_full_d;
      tx_done_q   <= tx_done_d;
    end
  end

  assign tx       = tx_q;
  assign tx_ready = tx_ready_q;
  assign tx_busy  = tx_busy_q;
  assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: 8N1 instance at BAUD_DIV=4 and 8N2 instance at BAUD_DIV=3.
module tb_uart_tx_frame;

  logic       clk;
  logic       rst_n, rst_n2;
  logic       tx_valid, tx_valid2;
  logic [7:0] tx_data, tx_data2;
  logic       tx_ready, tx, tx_busy, tx_done;
  logic       tx_ready2, tx2, tx_busy2, tx_done2;

  int vec  = 0;
  int miss = 0;

  uart_tx_frame #(
    .BAUD_DIV  (4),
    .STOP_BITS (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .tx       (tx),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  uart_tx_frame #(
    .BAUD_DIV  (3),
    .STOP_BITS (2)
  ) dut2 (
    .clk      (clk),
    .rst_n    (rst_n2),
    .tx_valid (tx_valid2),
    .tx_data  (tx_data2),
    .tx_ready (tx_ready2),
    .tx       (tx2),
    .tx_busy  (tx_busy2),
    .tx_done  (tx_done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rst_n2 = 1'b0;
    repeat (3) tick();
    vec++;
    if (tx !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
      miss++;
      $display("FAIL reset_values tx=%b ready=%b busy=%b done=%b required 1 1 0 0",
               tx, tx_ready, tx_busy, tx_done);
    end
    vec++;
    if (tx2 !== 1'b1 || tx_ready2 !== 1'b1 || tx_busy2 !== 1'b0 || tx_done2 !== 1'b0) begin
      miss++;
      $display("FAIL reset_values2 tx=%b ready=%b busy=%b done=%b required 1 1 0 0",
               tx2, tx_ready2, tx_busy2, tx_done2);
    end
    rst_n = 1'b1;
    rst_n2 = 1'b1;
    for (int c = 0; c < 100; c++) begin
      tick();
      vec++;
      if (tx !== 1'b1 || tx2 !== 1'b1) begin
        miss++;
        $display("FAIL idle_line cycle %0d tx=%b tx2=%b required 1 1", c, tx, tx2);
      end
    end
  endtask

  task automatic test_single();
    logic [9:0] frame;
    frame = 10'b1_1010_0101_0;  // stop, 0xA5, start
    tx_data = 8'hA5;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    vec++;
    if (tx !== 1'b1 || tx_ready !== 1'b0) begin
      miss++;
      $display("FAIL single_accept tx=%b ready=%b required tx=1 ready=0", tx, tx_ready);
    end
    tick();
    for (int c = 0; c < 40; c++) begin
      vec++;
      if (tx !== frame[c / 4]) begin
        miss++;
        $display("FAIL single_bit cycle %0d tx=%b required %b", c, tx, frame[c / 4]);
      end
      vec++;
      if (tx_done !== (c == 39) || tx_busy !== 1'b1) begin
        miss++;
        $display("FAIL single_done cycle %0d done=%b busy=%b required done=%b busy=1",
                 c, tx_done, tx_busy, (c == 39));
      end
      tick();
    end
    vec++;
    if (tx_busy !== 1'b0 || tx_done !== 1'b0 || tx !== 1'b1) begin
      miss++;
      $display("FAIL single_end busy=%b done=%b tx=%b required 0 0 1", tx_busy, tx_done, tx);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] f1, f2;
    logic       exp_bit, exp_rdy;
    f1 = 10'b1_0000_0000_0;
    f2 = 10'b1_1111_1111_0;
    tx_data = 8'h00;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tick();
    for (int c = 0; c < 80; c++) begin
      exp_bit = (c < 40) ? f1[c / 4] : f2[(c - 40) / 4];
      exp_rdy = !(c >= 11 && c <= 39);
      vec++;
      if (tx !== exp_bit) begin
        miss++;
        $display("FAIL b2b_bit cycle %0d tx=%b required %b", c, tx, exp_bit);
      end
      vec++;
      if (tx_ready !== exp_rdy || tx_done !== (c == 39 || c == 79)) begin
        miss++;
        $display("FAIL b2b_ctrl cycle %0d ready=%b done=%b required ready=%b done=%b",
                 c, tx_ready, tx_done, exp_rdy, (c == 39 || c == 79));
      end
      if (c == 10) begin
        tx_data = 8'hFF;
        tx_valid = 1'b1;
      end
      tick();
      tx_valid = 1'b0;
    end
    vec++;
    if (tx_busy !== 1'b0 || tx !== 1'b1) begin
      miss++;
      $display("FAIL b2b_end busy=%b tx=%b required 0 1", tx_busy, tx);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] src [3];
    logic [7:0] rx [4];
    logic [7:0] sh;
    logic       act;
    int         acc, nrx, rc;
    src[0] = 8'h11;
    src[1] = 8'h22;
    src[2] = 8'h33;
    acc = 0;
    nrx = 0;
    rc = 0;
    act = 1'b0;
    sh = '0;
    tx_data = src[0];
    tx_valid = 1'b1;
    for (int c = 0; c < 130; c++) begin
      // Line decoder: sample mid-bit relative to the first start-bit cycle.
      if (!act) begin
        if (tx == 1'b0) begin
          act = 1'b1;
          rc = 0;
        end
      end else begin
        rc++;
        if (rc >= 6 && rc <= 34 && (rc - 2) % 4 == 0) sh = {tx, sh[7:1]};
        if (rc == 38) begin
          if (nrx < 4) rx[nrx] = sh;
          nrx++;
          act = 1'b0;
        end
      end
      if (tx_valid && tx_ready) acc++;
      tick();
      if (acc < 3) tx_data = src[acc];
      else tx_valid = 1'b0;
    end
    vec++;
    if (acc !== 3 || nrx !== 3) begin
      miss++;
      $display("FAIL bp_count accepted=%0d decoded=%0d required 3 3", acc, nrx);
    end
    for (int i = 0; i < 3; i++) begin
      vec++;
      if (i < nrx && rx[i] !== src[i]) begin
        miss++;
        $display("FAIL bp_byte %0d got %h required %h", i, rx[i], src[i]);
      end
    end
    vec++;
    if (tx_busy !== 1'b0) begin
      miss++;
      $display("FAIL bp_end busy=%b required 0", tx_busy);
    end
  endtask

  task automatic test_reset_mid();
    tx_data = 8'hF7;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tick();
    tx_data = 8'h3C;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    repeat (16) tick();
    vec++;
    if (tx !== 1'b0 || tx_ready !== 1'b0) begin
      miss++;
      $display("FAIL mid_pre tx=%b ready=%b required 0 0", tx, tx_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    vec++;
    if (tx !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0) begin
      miss++;
      $display("FAIL mid_async tx=%b ready=%b busy=%b required 1 1 0", tx, tx_ready, tx_busy);
    end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 60; c++) begin
      tick();
      vec++;
      if (tx !== 1'b1 || tx_done !== 1'b0 || tx_ready !== 1'b1 || tx_busy !== 1'b0) begin
        miss++;
        $display("FAIL mid_after cycle %0d tx=%b done=%b ready=%b busy=%b required 1 0 1 0",
                 c, tx, tx_done, tx_ready, tx_busy);
      end
    end
  endtask

  task automatic test_two_stop();
    logic [7:0] d;
    logic       exp_bit;
    d = 8'h80;
    tx_data2 = d;
    tx_valid2 = 1'b1;
    tick();
    tx_valid2 = 1'b0;
    tick();
    for (int c = 0; c < 33; c++) begin
      if (c < 3) exp_bit = 1'b0;
      else if (c < 27) exp_bit = d[(c - 3) / 3];
      else exp_bit = 1'b1;
      vec++;
      if (tx2 !== exp_bit || tx_done2 !== (c == 32)) begin
        miss++;
        $display("FAIL two_stop cycle %0d tx=%b done=%b required tx=%b done=%b",
                 c, tx2, tx_done2, exp_bit, (c == 32));
      end
      tick();
    end
    vec++;
    if (tx_busy2 !== 1'b0 || tx2 !== 1'b1 || tx_done2 !== 1'b0) begin
      miss++;
      $display("FAIL two_stop_end busy=%b tx=%b done=%b required 0 1 0",
               tx_busy2, tx2, tx_done2);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rst_n2 = 1'b0;
    tx_valid = 1'b0;
    tx_valid2 = 1'b0;
    tx_data = '0;
    tx_data2 = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_two_stop();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
